// File: rtl/div_iter.sv
// Iterative restoring divider: 2W-bit unsigned dividend by W-bit divisor,
// BPC quotient bits per cycle, valid/ready handshake on both sides.
module div_iter #(
  parameter int W   = 32,
  parameter int BPC = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] x,
  input  logic [W-1:0]   d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           dz,
  output logic           ovf
);

  localparam int STEPS = W / BPC;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [W:0]     rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   d_q, d_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   r_q, r_d;
  logic           dz_q, dz_d;
  logic           ovf_q, ovf_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     rem_v;
  logic [W-1:0]   quo_v;

  always_comb begin
    // BPC restoring steps; quo holds the unconsumed dividend bits on the left
    // and the freshly resolved quotient bits filling in from the right.
    rem_v = rem_q;
    quo_v = quo_q;
    for (int i = 0; i < BPC; i++) begin
      rem_v = {rem_v[W-1:0], quo_v[W-1]};
      quo_v = {quo_v[W-2:0], 1'b0};
      if (rem_v >= {1'b0, d_q}) begin
        rem_v    = rem_v - {1'b0, d_q};
        quo_v[0] = 1'b1;
      end
    end

    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          d_d   = d;
          quo_d = x[W-1:0];
          rem_d = {1'b0, x[2*W-1:W]};
          cnt_d = CW'(STEPS - 1);
          if (d == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
            q_d     = '1;
            r_d     = x[W-1:0];
          end else if (x[2*W-1:W] >= d) begin
            state_d = DONE;
            dz_d    = 1'b0;
            ovf_d   = 1'b1;
            q_d     = '1;
            r_d     = x[W-1:0];
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = rem_v;
        quo_d = quo_v;
        if (cnt_q == '0) begin
          state_d = DONE;
          q_d     = quo_v;
          r_d     = rem_v[W-1:0];
          dz_d    = 1'b0;
          ovf_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign q         = q_q;
  assign r         = r_q;
  assign dz        = dz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: one BPC=1 and one BPC=4 instance (W=32),
// hand-computed results, latency, backpressure and reset-abort checks.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid4;
  logic        out_ready, out_ready4;
  logic [63:0] x;
  logic [31:0] d;
  logic        in_ready, out_valid, dz, ovf;
  logic [31:0] q, r;
  logic        in_ready4, out_valid4, dz4, ovf4;
  logic [31:0] q4, r4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_iter #(.W(32), .BPC(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .d(d), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .r(r), .dz(dz), .ovf(ovf)
  );

  div_iter #(.W(32), .BPC(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .x(x), .d(d), .out_valid(out_valid4), .out_ready(out_ready4),
    .q(q4), .r(r4), .dz(dz4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one request to the BPC=1 instance; returns just after the accept
  // edge with the inputs scrambled so late changes would show up as errors.
  task automatic send(input logic [63:0] xv, input logic [31:0] dv);
    x        = xv;
    d        = dv;
    in_valid = 1'b1;
    chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x        = {$urandom, $urandom};
    d        = $urandom;
  endtask

  // Number of edges after the accept edge until out_valid is seen (0 = the
  // cycle right after accept).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("in_ready_after_handoff", {63'd0, in_ready}, 64'd1);
    chk("out_valid_after_handoff", {63'd0, out_valid}, 64'd0);
  endtask

  task automatic run(input string tag, input logic [63:0] xv, input logic [31:0] dv,
                     input logic [31:0] eq, input logic [31:0] er,
                     input logic edz, input logic eovf, input int elat);
    int lat;
    send(xv, dv);
    wait_done(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_q"},   {32'd0, q}, {32'd0, eq});
    chk({tag, "_r"},   {32'd0, r}, {32'd0, er});
    chk({tag, "_dz"},  {63'd0, dz}, {63'd0, edz});
    chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eovf});
    $display("txn %s x=%0h d=%0h q=%0h r=%0h dz=%0b ovf=%0b lat=%0d",
             tag, xv, dv, q, r, dz, ovf, lat);
    handoff();
  endtask

  initial begin
    int lat;
    logic seen;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_valid4  = 1'b0;
    out_ready  = 1'b0;
    out_ready4 = 1'b0;
    x          = '0;
    d          = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_q", {32'd0, q}, 64'd0);
    chk("reset_r", {32'd0, r}, 64'd0);
    chk("reset_dz_ovf", {62'd0, dz, ovf}, 64'd0);

    // First accept in the first cycle after reset; then hold the result.
    send(64'd100, 32'd7);
    chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
    wait_done(lat);
    chk("div100_7_lat", 64'(lat), 64'd32);
    chk("div100_7_q", {32'd0, q}, 64'd14);
    chk("div100_7_r", {32'd0, r}, 64'd2);
    chk("div100_7_flags", {62'd0, dz, ovf}, 64'd0);
    $display("txn div100_7 q=%0d r=%0d lat=%0d", q, r, lat);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_q", {32'd0, q}, 64'd14);
      chk("bp_r", {32'd0, r}, 64'd2);
      chk("bp_state", {62'd0, in_ready, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    handoff();

    run("dz",      64'h1234,                32'd0,         32'hFFFF_FFFF, 32'h1234,      1'b1, 1'b0, 0);
    run("ovf_eq",  64'h5_0000_0000,         32'd5,         32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 0);
    run("ovf_gt",  64'h0001_0000_0000_0007, 32'd3,         32'hFFFF_FFFF, 32'h7,         1'b0, 1'b1, 0);
    run("eq49_7",  64'd49,                  32'd7,         32'd7,         32'd0,         1'b0, 1'b0, 32);
    run("max",     64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0, 32);
    run("max_rem", 64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 32);
    run("pow32_3", 64'h1_0000_0000,         32'd3,         32'h5555_5555, 32'd1,         1'b0, 1'b0, 32);
    run("zero_x",  64'd0,                   32'd9,         32'd0,         32'd0,         1'b0, 1'b0, 32);

    // Reset in the middle of a BUSY run: no result may appear afterwards.
    send(64'd1000, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_q_cleared", {32'd0, q}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk("abort_no_out_valid", {63'd0, seen}, 64'd0);
    run("after_abort", 64'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 32);

    // BPC=4 instance: eight BUSY cycles.
    x         = 64'h0000_0001_0000_0000;
    d         = 32'd3;
    in_valid4 = 1'b1;
    chk("bpc4_in_ready", {63'd0, in_ready4}, 64'd1);
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    x         = '1;
    d         = 32'd1;
    lat = 0;
    while (!out_valid4 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bpc4_lat", 64'(lat), 64'd8);
    chk("bpc4_q", {32'd0, q4}, 64'h5555_5555);
    chk("bpc4_r", {32'd0, r4}, 64'd1);
    chk("bpc4_flags", {62'd0, dz4, ovf4}, 64'd0);
    $display("txn bpc4 q=%0h r=%0h lat=%0d", q4, r4, lat);
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    out_ready4 = 1'b0;
    chk("bpc4_in_ready_after", {63'd0, in_ready4}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
